// File: rtl/blink_rtc_timer.sv
// blink_rtc_timer: tick/sec/min RTC with masked status interrupt; RTC_SNAPSHOT_EN makes multi-byte TIM reads coherent
module blink_rtc_timer #(
  parameter int TICK_DIV = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int SECS_PER_MIN = 60,
  parameter int MIN_W = 21,
  parameter logic [7:0] PORT_TACK = 8'hB4,
  parameter logic [7:0] PORT_TSTA = 8'hB5,
  parameter logic [7:0] PORT_TIM = 8'hD0
) (
  input  logic       mck,
  input  logic       rin_n,
  input  logic       flp,
  input  logic       restim,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [7:0] port,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rdata_vld,
  output logic [2:0] tsta,
  output logic       rtcs,
  output logic       t_1s,
  output logic       t_5ms
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic [7:0] tim0, off, rd_val;
  logic [5:0] tim1, tim1_rd;
  logic [MIN_W-1:0] timm, timm_rd;
  logic [23:0] timm_x;
  logic [2:0] tmk;
  logic tick, sec, min, wr_tack, wr_tsta, rd_hit, unused;
  assign tick = pre == PW'(TICK_DIV - 1);
  assign sec = tick && tim0 == 8'(TICKS_PER_SEC - 1);
  assign min = sec && tim1 == 6'(SECS_PER_MIN - 1);
  assign wr_tack = reg_wr && port == PORT_TACK;
  assign wr_tsta = reg_wr && port == PORT_TSTA;
  assign rtcs = |(tsta & tmk);
  assign t_1s = tim0[7];
  assign t_5ms = tim0[1];
  assign unused = ^wdata[7:3];
  always_ff @(posedge mck)
    if ((!rin_n && flp) || (rin_n && restim)) begin
      pre <= '0;
      tim0 <= '0;
      tim1 <= '0;
      timm <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) tim0 <= sec ? '0 : tim0 + 8'd1;
      if (sec) tim1 <= min ? '0 : tim1 + 6'd1;
      if (min) timm <= timm + 1'b1;
    end
  always_ff @(posedge mck)
    if (!rin_n) begin
      tsta <= '0;
      tmk <= '0;
      rdata <= '0;
      rdata_vld <= 1'b0;
    end else begin
      tsta <= (tsta & ~(wr_tack ? wdata[2:0] : 3'b0)) | (restim ? 3'b0 : {min, sec, tick});
      if (wr_tsta) tmk <= wdata[2:0];
      if (reg_rd && rd_hit) rdata <= rd_val;
      rdata_vld <= reg_rd && rd_hit;
    end
`ifdef RTC_SNAPSHOT_EN
  logic [5:0] snap_tim1;
  logic [MIN_W-1:0] snap_timm;
  always_ff @(posedge mck)
    if (!rin_n) begin
      snap_tim1 <= '0;
      snap_timm <= '0;
    end else if (reg_rd && port == PORT_TIM) begin
      snap_tim1 <= tim1;
      snap_timm <= timm;
    end
  assign tim1_rd = snap_tim1;
  assign timm_rd = snap_timm;
`else
  assign tim1_rd = tim1;
  assign timm_rd = timm;
`endif
  assign timm_x = 24'(timm_rd);
  always_comb begin
    off = port - PORT_TIM;
    rd_hit = port == PORT_TSTA || off < 8'd5;
    rd_val = port == PORT_TSTA ? {5'b0, tsta} :
             off == 8'd0 ? tim0 :
             off == 8'd1 ? {2'b0, tim1_rd} :
             off == 8'd2 ? timm_x[7:0] :
             off == 8'd3 ? timm_x[15:8] : timm_x[23:16];
  end
endmodule

// File: tb/tb_blink_rtc_timer.sv
// tb_blink_rtc_timer: directed checks of blink_rtc_timer with a 4-cycle tick, 3 ticks/sec, 2 secs/min
module tb_blink_rtc_timer;
  localparam logic [7:0] TACK = 8'hB4, TSTA = 8'hB5, TIM = 8'hD0;
  logic mck = 1'b0, rin_n = 1'b0, flp = 1'b1, restim = 1'b0, reg_wr = 1'b0, reg_rd = 1'b0;
  logic [7:0] port = '0, wdata = '0, rdata;
  logic rdata_vld, rtcs, t_1s, t_5ms;
  logic [2:0] tsta;
  int cyc, n_cmp, n_bad;
  blink_rtc_timer #(.TICK_DIV(4), .TICKS_PER_SEC(3), .SECS_PER_MIN(2), .MIN_W(21)) dut (
    .mck(mck), .rin_n(rin_n), .flp(flp), .restim(restim), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .port(port), .wdata(wdata), .rdata(rdata), .rdata_vld(rdata_vld), .tsta(tsta),
    .rtcs(rtcs), .t_1s(t_1s), .t_5ms(t_5ms));
  always #5 mck = ~mck;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge mck);
    cyc++;
  endtask
  task automatic run_to(int t);
    while (cyc < t) step();
  endtask
  task automatic wr(logic [7:0] p, logic [7:0] d);
    port = p;
    wdata = d;
    reg_wr = 1'b1;
    step();
    reg_wr = 1'b0;
  endtask
  task automatic rd(string tag, logic [7:0] p, logic [7:0] exp);
    port = p;
    reg_rd = 1'b1;
    step();
    reg_rd = 1'b0;
    check(tag, rdata, exp);
    check({tag, "_vld"}, rdata_vld, 1);
  endtask
  task automatic rst(logic f);
    rin_n = 1'b0;
    flp = f;
    step();
    rin_n = 1'b1;
    flp = 1'b0;
  endtask
  initial begin
    @(negedge mck);
    rst(1'b1);
    cyc = 0;
    check("rst_tsta", tsta, 0);
    check("rst_rtcs", rtcs, 0);
    check("rst_rdata", rdata, 0);
    check("rst_vld", rdata_vld, 0);
    run_to(3);
    check("tsta_pre", tsta, 0);
    rd("tim0_a", TIM, 0);
    check("tsta_tick", tsta, 3'b001);
    run_to(7);
    rd("tim0_b", TIM, 1);
    run_to(11);
    rd("tim0_c", TIM, 2);
    check("tsta_sec", tsta, 3'b011);
    run_to(15);
    rd("tim0_d", TIM, 0);
    rd("tim1_a", TIM + 8'd1, 1);
    run_to(24);
    check("tsta_min", tsta, 3'b111);
    check("rtcs_masked", rtcs, 0);
    rd("timm_a", TIM + 8'd2, 1);
    port = 8'h55;
    reg_rd = 1'b1;
    step();
    reg_rd = 1'b0;
    check("undec_data", rdata, 1);
    check("undec_vld", rdata_vld, 0);
    wr(TACK, 8'h07);
    check("tack_all", tsta, 0);
    check("rtcs_idle", rtcs, 0);
    wr(TSTA, 8'h01);
    check("tsta_t", tsta, 3'b001);
    check("rtcs_set", rtcs, 1);
    wr(TACK, 8'h01);
    check("tack_clr", tsta, 0);
    check("rtcs_clr", rtcs, 0);
    run_to(31);
    wr(TACK, 8'h01);
    check("set_wins", tsta, 3'b001);
    check("set_wins_rtcs", rtcs, 1);
    run_to(121);
    rst(1'b0);
    check("soft_tsta", tsta, 0);
    check("soft_rtcs", rtcs, 0);
    check("soft_rdata", rdata, 0);
    check("soft_vld", rdata_vld, 0);
    rd("soft_timm", TIM + 8'd2, 5);
    run_to(126);
    check("soft_tick", tsta, 3'b001);
    check("soft_tmk", rtcs, 0);
    rst(1'b1);
    cyc = 0;
    check("hard_tsta", tsta, 0);
    rd("hard_tim0", TIM, 0);
    rd("hard_tim1", TIM + 8'd1, 0);
    rd("hard_timm", TIM + 8'd2, 0);
    run_to(6);
    restim = 1'b1;
    run_to(10);
    check("restim_tsta", tsta, 3'b001);
    rd("restim_tim0", TIM, 0);
    rd("restim_tim1", TIM + 8'd1, 0);
    rd("restim_timm", TIM + 8'd2, 0);
    wr(TACK, 8'h07);
    run_to(26);
    check("restim_hold", tsta, 0);
    restim = 1'b0;
    run_to(29);
    check("rel_pre", tsta, 0);
    step();
    check("rel_tick", tsta, 3'b001);
    run_to(48);
    check("t_5ms", t_5ms, 1);
    check("t_1s", t_1s, 0);
    rd("snap_tim0", TIM, 2);
    step();
    check("snap_tsta", tsta, 3'b111);
`ifdef RTC_SNAPSHOT_EN
    rd("snap_tim1", TIM + 8'd1, 1);
    rd("snap_timm", TIM + 8'd2, 0);
`else
    rd("live_tim1", TIM + 8'd1, 0);
    rd("live_timm", TIM + 8'd2, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
